// File: rtl/ntt_bfu.sv
// ============================================================================
// ntt_bfu : streaming CT/GS radix-2 butterfly around a pipelined Montgomery mul
// Revision : 1.0
// ============================================================================
`default_nettype none

package ntt_pkg;
  localparam int unsigned DATA_WIDTH = 12;
  localparam int unsigned Q          = 3329;
endpackage

// Radix-2 interleaved Montgomery multiplier: p = a*b*2^-DATA_WIDTH mod Q, p in 0..2Q-1.
// One register per bit of a plus an input and an output register.
module mo_mul
  import ntt_pkg::*;
(
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH:0]   p
);
  localparam int unsigned TW = DATA_WIDTH + 2;

  logic [DATA_WIDTH-1:0] a_q [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] b_q [DATA_WIDTH];
  logic [TW-1:0]         t_q [DATA_WIDTH+1];
  logic [DATA_WIDTH:0]   p_q;

  always_ff @(posedge clk) begin
    a_q[0] <= a;
    b_q[0] <= b;
    t_q[0] <= '0;
  end

  // t stays below 2Q, so t + b + Q never exceeds TW bits
  for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_step
    logic [TW-1:0] sum, odd;
    always_comb begin
      sum = t_q[k] + (a_q[k][0] ? TW'(b_q[k]) : '0);
      odd = sum + (sum[0] ? TW'(Q) : '0);
    end
    always_ff @(posedge clk) begin
      t_q[k+1] <= odd >> 1;
    end
    if (k < DATA_WIDTH - 1) begin : g_fwd
      always_ff @(posedge clk) begin
        a_q[k+1] <= a_q[k] >> 1;
        b_q[k+1] <= b_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    p_q <= t_q[DATA_WIDTH][DATA_WIDTH:0];
  end

  assign p = p_q;
endmodule

module ntt_bfu
  import ntt_pkg::*;
#(
  parameter int unsigned MUL_LAT = DATA_WIDTH + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_mode,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [DATA_WIDTH-1:0] in_w,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic                  busy
);
  localparam logic [DATA_WIDTH:0]   QX = (DATA_WIDTH+1)'(Q);
  localparam logic [DATA_WIDTH-1:0] QW = DATA_WIDTH'(Q);

  logic [DATA_WIDTH:0]   sum, dif, prod, fsum, fdif;
  logic [DATA_WIDTH-1:0] x_d, m_d, pn, x_f, oa_d, ob_d;
  logic [DATA_WIDTH-1:0] x_p_q, m_p_q, w_p_q, out_a_q, out_b_q;
  logic [DATA_WIDTH-1:0] x_sr_q [MUL_LAT];
  logic [MUL_LAT-1:0]    vld_sr_q, mode_sr_q;
  logic                  vld_p_q, mode_p_q, out_valid_q;

  always_comb begin
    sum = {1'b0, in_a} + {1'b0, in_b};
    dif = {1'b0, in_a} - {1'b0, in_b};
    x_d = in_a;
    m_d = in_b;
    if (in_mode) begin
      x_d = (sum >= QX) ? DATA_WIDTH'(sum - QX) : sum[DATA_WIDTH-1:0];
      m_d = dif[DATA_WIDTH] ? DATA_WIDTH'(dif + QX) : dif[DATA_WIDTH-1:0];
    end
  end

  // m_op is always < Q, so it takes port a of the multiplier
  mo_mul u_mul (
    .clk (clk),
    .a   (m_p_q),
    .b   (w_p_q),
    .p   (prod)
  );

  always_comb begin
    pn   = (prod >= QX) ? DATA_WIDTH'(prod - QX) : prod[DATA_WIDTH-1:0];
    x_f  = x_sr_q[MUL_LAT-1];
    fsum = {1'b0, x_f} + {1'b0, pn};
    fdif = {1'b0, x_f} - {1'b0, pn};
    oa_d = x_f;
    ob_d = pn;
    if (!mode_sr_q[MUL_LAT-1]) begin
      oa_d = (fsum >= QX) ? DATA_WIDTH'(fsum - QX) : fsum[DATA_WIDTH-1:0];
      ob_d = fdif[DATA_WIDTH] ? DATA_WIDTH'(fdif + QX) : fdif[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p_q     <= 1'b0;
      mode_p_q    <= 1'b0;
      vld_sr_q    <= '0;
      mode_sr_q   <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else begin
      vld_p_q     <= in_valid;
      mode_p_q    <= in_mode;
      vld_sr_q    <= {vld_sr_q[MUL_LAT-2:0], vld_p_q};
      mode_sr_q   <= {mode_sr_q[MUL_LAT-2:0], mode_p_q};
      out_valid_q <= vld_sr_q[MUL_LAT-1];
      if (vld_sr_q[MUL_LAT-1]) begin
        out_a_q <= oa_d;
        out_b_q <= ob_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    x_p_q     <= x_d;
    m_p_q     <= m_d;
    w_p_q     <= in_w;
    x_sr_q[0] <= x_p_q;
    for (int unsigned i = 1; i < MUL_LAT; i++) begin
      x_sr_q[i] <= x_sr_q[i-1];
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign busy      = vld_p_q | (|vld_sr_q) | out_valid_q;

  a_in_range: assert property (@(posedge clk) disable iff (rst)
    in_valid |-> (in_a < QW && in_b < QW && in_w < QW));
endmodule

`default_nettype wire
